// File: rtl/regfile_16x32_pkg.sv
// Shared constants, types and the write-decode helper for the 16x32 register file.
package regfile_16x32_pkg;

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned DATA_W   = 32;

  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 4'd0;
  localparam reg_addr_t REG_SP   = 4'd15;

  // One-hot write select, all zero when the write is not enabled
  function automatic logic [NUM_REGS-1:0] onehot_dec(input reg_addr_t addr, input logic en);
    return en ? (NUM_REGS'(1) << addr) : '0;
  endfunction

endpackage

// File: rtl/regfile_16x32_if.sv
// Read/write bus of the register file; master drives addresses and write data.
interface regfile_16x32_if
  import regfile_16x32_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
);

  reg_addr_t          rs_addr;
  reg_addr_t          rt_addr;
  logic [WIDTH-1:0]   rs_data;
  logic [WIDTH-1:0]   rt_data;
  logic               wr_en;
  reg_addr_t          wr_addr;
  logic [WIDTH-1:0]   wr_data;
  logic [WIDTH-1:0]   sp_data;

  modport master (
    output rs_addr, rt_addr, wr_en, wr_addr, wr_data,
    input  rs_data, rt_data, sp_data
  );

  modport slave (
    input  rs_addr, rt_addr, wr_en, wr_addr, wr_data,
    output rs_data, rt_data, sp_data
  );

endinterface

// File: rtl/MUX16TO1_32BIT.sv
// 16-to-1 read multiplexer selecting one register-file entry.
module MUX16TO1_32BIT
  import regfile_16x32_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0] i_data [NUM_REGS],
  input  reg_addr_t        i_sel,
  output logic [WIDTH-1:0] o_data
);

  assign o_data = i_data[i_sel];

endmodule

// File: rtl/regfile_16x32.sv
// 16x32 register file: two combinational read ports with write-through,
// one synchronous write port, optional hardwired zero register, resettable SP.
module regfile_16x32
  import regfile_16x32_pkg::*;
#(
  parameter int unsigned     WIDTH    = DATA_W,
  parameter bit              ZERO_REG = 1'b1,
  parameter logic [WIDTH-1:0] SP_RESET = WIDTH'(32'h0000_0FFC),
  parameter bit              BYPASS   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  regfile_16x32_if.slave  bus
);

  logic [WIDTH-1:0]    r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] w_wr_sel;
  logic [WIDTH-1:0]    w_rs_mux;
  logic [WIDTH-1:0]    w_rt_mux;
  logic [WIDTH-1:0]    w_rs_data;
  logic [WIDTH-1:0]    w_rt_data;
  logic [WIDTH-1:0]    w_sp_data;
  logic                w_byp_ok;

  // Writes to the zero register never reach storage
  always_comb begin
    w_wr_sel = onehot_dec(bus.wr_addr, bus.wr_en);
    if (ZERO_REG) begin
      w_wr_sel[REG_ZERO] = 1'b0;
    end
  end

  // Reset takes priority over any write on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        r_regs[i] <= (ADDR_W'(i) == REG_SP) ? SP_RESET : '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if (w_wr_sel[i]) begin
          r_regs[i] <= bus.wr_data;
        end
      end
    end
  end

  MUX16TO1_32BIT #(.WIDTH(WIDTH)) u_mux_rs (
    .i_data (r_regs),
    .i_sel  (bus.rs_addr),
    .o_data (w_rs_mux)
  );

  MUX16TO1_32BIT #(.WIDTH(WIDTH)) u_mux_rt (
    .i_data (r_regs),
    .i_sel  (bus.rt_addr),
    .o_data (w_rt_mux)
  );

  // Post-mux override: zero register first, then write-through
  always_comb begin
    w_byp_ok  = BYPASS && bus.wr_en && !rst &&
                !(ZERO_REG && (bus.wr_addr == REG_ZERO));
    w_rs_data = w_rs_mux;
    w_rt_data = w_rt_mux;
    w_sp_data = r_regs[REG_SP];
    if (ZERO_REG && (bus.rs_addr == REG_ZERO)) begin
      w_rs_data = '0;
    end else if (w_byp_ok && (bus.rs_addr == bus.wr_addr)) begin
      w_rs_data = bus.wr_data;
    end
    if (ZERO_REG && (bus.rt_addr == REG_ZERO)) begin
      w_rt_data = '0;
    end else if (w_byp_ok && (bus.rt_addr == bus.wr_addr)) begin
      w_rt_data = bus.wr_data;
    end
    if (w_byp_ok && (bus.wr_addr == REG_SP)) begin
      w_sp_data = bus.wr_data;
    end
  end

  assign bus.rs_data = w_rs_data;
  assign bus.rt_data = w_rt_data;
  assign bus.sp_data = w_sp_data;

endmodule

// File: tb/tb_regfile_16x32.sv
// Directed bench for regfile_16x32: a bypassing and a non-bypassing instance
// share stimulus; expected read values are queued and checked at the falling edge.
module tb_regfile_16x32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  regfile_16x32_if bus ();
  regfile_16x32_if bus_nb ();

  regfile_16x32 u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  regfile_16x32 #(.BYPASS(1'b0)) u_dut_nb (
    .clk (clk),
    .rst (rst),
    .bus (bus_nb)
  );

  typedef struct {
    string       name;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] sp;
    logic [31:0] nb_rs;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s got %h expected %h", nm, fld, act, exp);
    end
  endtask

  // Monitor: one queued expectation per cycle, sampled before the next rising edge
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk(e.name, "rs", bus.rs_data, e.rs);
      chk(e.name, "rt", bus.rt_data, e.rt);
      chk(e.name, "sp", bus.sp_data, e.sp);
      chk(e.name, "nb_rs", bus_nb.rs_data, e.nb_rs);
    end
  end

  task automatic step(input string nm, input logic r, input logic we,
                      input logic [3:0] wa, input logic [31:0] wd,
                      input logic [3:0] ra, input logic [3:0] rb,
                      input logic [31:0] e_rs, input logic [31:0] e_rt,
                      input logic [31:0] e_sp, input logic [31:0] e_nb);
    exp_t e;
    rst            = r;
    bus.wr_en      = we;  bus_nb.wr_en   = we;
    bus.wr_addr    = wa;  bus_nb.wr_addr = wa;
    bus.wr_data    = wd;  bus_nb.wr_data = wd;
    bus.rs_addr    = ra;  bus_nb.rs_addr = ra;
    bus.rt_addr    = rb;  bus_nb.rt_addr = rb;
    e.name = nm; e.rs = e_rs; e.rt = e_rt; e.sp = e_sp; e.nb_rs = e_nb;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] SP0 = 32'h0000_0FFC;

  initial begin
    logic [3:0]  ia;
    logic [3:0]  ib;
    logic [31:0] ea;
    logic [31:0] eb;
    int          wait_cyc;

    bus.wr_en = 1'b0;   bus_nb.wr_en = 1'b0;
    bus.wr_addr = '0;   bus_nb.wr_addr = '0;
    bus.wr_data = '0;   bus_nb.wr_data = '0;
    bus.rs_addr = '0;   bus_nb.rs_addr = '0;
    bus.rt_addr = '0;   bus_nb.rt_addr = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset contents on every index, both ports
    for (int i = 0; i < 16; i++) begin
      ia = 4'(i);
      ib = 4'(15 - i);
      ea = (i == 15) ? SP0 : 32'h0;
      eb = (i == 0) ? SP0 : 32'h0;
      step("reset_rd", 1'b0, 1'b0, 4'd0, 32'h0, ia, ib, ea, eb, SP0, ea);
    end

    // Basic write and read-back
    step("wr_r5",     1'b0, 1'b1, 4'd5, 32'hDEAD_BEEF, 4'd5, 4'd4, 32'hDEAD_BEEF, 32'h0, SP0, 32'h0);
    step("rd_r5",     1'b0, 1'b0, 4'd5, 32'h0, 4'd5, 4'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, SP0, 32'hDEAD_BEEF);
    step("rd_other",  1'b0, 1'b0, 4'd5, 32'h0, 4'd6, 4'd15, 32'h0, SP0, SP0, 32'h0);

    // Zero register ignores writes, no bypass leak
    step("wr_r0",     1'b0, 1'b1, 4'd0, 32'h1234_5678, 4'd0, 4'd0, 32'h0, 32'h0, SP0, 32'h0);
    step("rd_r0",     1'b0, 1'b0, 4'd0, 32'h0, 4'd0, 4'd5, 32'h0, 32'hDEAD_BEEF, SP0, 32'h0);

    // Write-through versus registered view
    step("wr_r7_11",  1'b0, 1'b1, 4'd7, 32'h0000_0011, 4'd3, 4'd7, 32'h0, 32'h0000_0011, SP0, 32'h0);
    step("byp_r7_22", 1'b0, 1'b1, 4'd7, 32'h0000_0022, 4'd7, 4'd7, 32'h0000_0022, 32'h0000_0022, SP0, 32'h0000_0011);
    step("rd_r7",     1'b0, 1'b0, 4'd7, 32'h0, 4'd7, 4'd7, 32'h0000_0022, 32'h0000_0022, SP0, 32'h0000_0022);

    // Bit-exact pattern, no extension
    step("wr_r9",     1'b0, 1'b1, 4'd9, 32'h8000_0001, 4'd9, 4'd9, 32'h8000_0001, 32'h8000_0001, SP0, 32'h0);
    step("rd_r9",     1'b0, 1'b0, 4'd9, 32'h0, 4'd9, 4'd3, 32'h8000_0001, 32'h0, SP0, 32'h8000_0001);

    // Stack pointer write with sp_data bypass
    step("wr_sp",     1'b0, 1'b1, 4'd15, 32'hCAFE_0001, 4'd15, 4'd7, 32'hCAFE_0001, 32'h0000_0022, 32'hCAFE_0001, SP0);
    step("rd_sp",     1'b0, 1'b0, 4'd15, 32'h0, 4'd15, 4'd15, 32'hCAFE_0001, 32'hCAFE_0001, 32'hCAFE_0001, 32'hCAFE_0001);

    // Reset and write on the same edge: no bypass while in reset, reset wins
    step("rst_wr",    1'b1, 1'b1, 4'd15, 32'hFFFF_FFFF, 4'd15, 4'd5, 32'hCAFE_0001, 32'hDEAD_BEEF, 32'hCAFE_0001, 32'hCAFE_0001);
    step("post_rst",  1'b0, 1'b0, 4'd15, 32'h0, 4'd15, 4'd5, SP0, 32'h0, SP0, SP0);
    step("post_rst7", 1'b0, 1'b0, 4'd15, 32'h0, 4'd7, 4'd9, 32'h0, 32'h0, SP0, 32'h0);

    // Write enable low holds contents
    for (int i = 0; i < 4; i++) begin
      step("we_low", 1'b0, 1'b0, 4'd3, 32'hAAAA_AAAA, 4'd3, 4'd3, 32'h0, 32'h0, SP0, 32'h0);
    end
    step("we_low_end", 1'b0, 1'b0, 4'd0, 32'h0, 4'd3, 4'd15, 32'h0, SP0, SP0, 32'h0);

    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 10) begin
      @(negedge clk);
      #1;
      wait_cyc++;
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
